// File: rtl/cable_tx_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cable_tx_sched_pkg : line codes, FSM encoding and helpers for the cable TX.
// Rev 1.0
// ---------------------------------------------------------------------------
package cable_tx_sched_pkg;

  localparam logic [3:0] O_IDLE0 = 4'b0111;
  localparam logic [3:0] O_IDLE1 = 4'b1011;
  localparam logic [3:0] O_IDLE2 = 4'b1101;
  localparam logic [3:0] O_IDLE3 = 4'b1110;
  localparam logic [3:0] HDR_HIT = 4'b0001;
  localparam logic [3:0] HDR_CMD = 4'b0010;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  function automatic logic [3:0] idle_code(input logic [1:0] ph);
    logic [3:0] code;
    case (ph)
      2'd0:    code = O_IDLE0;
      2'd1:    code = O_IDLE1;
      2'd2:    code = O_IDLE2;
      default: code = O_IDLE3;
    endcase
    return code;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cable_tx_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cable_tx_sched_if : hit / cmd valid-ready request bundle for one cable.
// Rev 1.0
// ---------------------------------------------------------------------------
interface cable_tx_sched_if #(
  parameter int HIT_NIB = 2,
  parameter int CMD_NIB = 3
);
  logic                   hit_valid;
  logic [4*HIT_NIB-1:0]   hit_data;
  logic                   hit_ready;
  logic                   cmd_valid;
  logic [4*CMD_NIB-1:0]   cmd_data;
  logic                   cmd_ready;

  modport master (
    output hit_valid, hit_data, cmd_valid, cmd_data,
    input  hit_ready, cmd_ready
  );

  modport slave (
    input  hit_valid, hit_data, cmd_valid, cmd_data,
    output hit_ready, cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/cable_tx_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cable_tx_arb : hit-priority grant with bounded hit run so cmd cannot starve.
// Rev 1.0
// ---------------------------------------------------------------------------
module cable_tx_arb #(
  parameter int MAX_HIT_RUN = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_en,
  input  wire logic i_idle,
  input  wire logic i_hit_valid,
  input  wire logic i_cmd_valid,
  output logic      o_hit_gnt,
  output logic      o_cmd_gnt
);

  localparam logic [3:0] C_MAX_RUN = 4'(MAX_HIT_RUN);

  logic [3:0] r_hit_run;
  logic       w_can_grant;
  logic       w_cmd_due;

  assign w_can_grant = i_en & i_idle & ~rst;
  assign w_cmd_due   = i_cmd_valid & (r_hit_run == C_MAX_RUN);
  assign o_hit_gnt   = w_can_grant & i_hit_valid & ~w_cmd_due;
  assign o_cmd_gnt   = w_can_grant & i_cmd_valid & ~o_hit_gnt;

  // Run only grows while cmd is actually waiting behind a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_run <= 4'd0;
    end else if (o_hit_gnt) begin
      r_hit_run <= i_cmd_valid ? r_hit_run + 4'd1 : 4'd0;
    end else if (o_cmd_gnt) begin
      r_hit_run <= 4'd0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cable_tx_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cable_tx_sched : per-cable 4-bit frame scheduler with idle rotation and counters.
// Rev 1.0
// ---------------------------------------------------------------------------
module cable_tx_sched
  import cable_tx_sched_pkg::*;
#(
  parameter int HIT_NIB     = 2,
  parameter int CMD_NIB     = 3,
  parameter int GAP         = 1,
  parameter int MAX_HIT_RUN = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_en,
  input  wire logic       i_cnt_clr,
  cable_tx_sched_if.slave tx,
  output logic [3:0]      o_out,
  output logic            o_busy,
  output logic [15:0]     o_hit_frames,
  output logic [15:0]     o_cmd_frames
);

  localparam int SH_NIB = (HIT_NIB > CMD_NIB) ? HIT_NIB : CMD_NIB;
  localparam int SH_W   = 4 * SH_NIB;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [SH_W-1:0] r_shreg;
  logic [2:0]      r_nib_cnt;
  logic [3:0]      r_gap_cnt;
  logic [1:0]      r_idle_ph;
  logic [3:0]      r_out;
  logic [3:0]      w_out_d;
  logic            w_idle_adv;
  logic [15:0]     r_hit_frames;
  logic [15:0]     r_cmd_frames;
  logic            w_hit_gnt;
  logic            w_cmd_gnt;
  logic [SH_W-1:0] w_hit_load;
  logic [SH_W-1:0] w_cmd_load;

  cable_tx_arb #(
    .MAX_HIT_RUN (MAX_HIT_RUN)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_en        (i_en),
    .i_idle      (r_state == S_IDLE),
    .i_hit_valid (tx.hit_valid),
    .i_cmd_valid (tx.cmd_valid),
    .o_hit_gnt   (w_hit_gnt),
    .o_cmd_gnt   (w_cmd_gnt)
  );

  assign tx.hit_ready = w_hit_gnt;
  assign tx.cmd_ready = w_cmd_gnt;

  // Payloads are left-aligned so the first nibble out is always the top one.
  assign w_hit_load = SH_W'(tx.hit_data) << (SH_W - 4 * HIT_NIB);
  assign w_cmd_load = SH_W'(tx.cmd_data) << (SH_W - 4 * CMD_NIB);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hit_gnt | w_cmd_gnt) w_state_nxt = S_SEND;
      S_SEND:  if (r_nib_cnt == 3'd1)     w_state_nxt = S_GAP;
      S_GAP:   if (r_gap_cnt == 4'd1)     w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_out_d    = idle_code(r_idle_ph);
    w_idle_adv = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hit_gnt)      w_out_d = HDR_HIT;
        else if (w_cmd_gnt) w_out_d = HDR_CMD;
        else                w_idle_adv = 1'b1;
      end
      S_SEND:  w_out_d    = r_shreg[SH_W-1 -: 4];
      S_GAP:   w_idle_adv = 1'b1;
      default: w_out_d    = O_IDLE0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_out     <= 4'd0;
      r_idle_ph <= 2'd0;
      r_shreg   <= '0;
      r_nib_cnt <= 3'd0;
      r_gap_cnt <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_d;
      if (w_idle_adv) r_idle_ph <= r_idle_ph + 2'd1;
      case (r_state)
        S_IDLE: begin
          if (w_hit_gnt) begin
            r_shreg   <= w_hit_load;
            r_nib_cnt <= 3'(HIT_NIB);
          end else if (w_cmd_gnt) begin
            r_shreg   <= w_cmd_load;
            r_nib_cnt <= 3'(CMD_NIB);
          end
        end
        S_SEND: begin
          r_shreg   <= r_shreg << 4;
          r_nib_cnt <= r_nib_cnt - 3'd1;
          if (r_nib_cnt == 3'd1) r_gap_cnt <= 4'(GAP);
        end
        S_GAP:   r_gap_cnt <= r_gap_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // A clear pulse beats a coincident grant.
  always_ff @(posedge clk) begin
    if (rst || i_cnt_clr) begin
      r_hit_frames <= 16'd0;
      r_cmd_frames <= 16'd0;
    end else begin
      if (w_hit_gnt) r_hit_frames <= sat_inc(r_hit_frames);
      if (w_cmd_gnt) r_cmd_frames <= sat_inc(r_cmd_frames);
    end
  end

  assign o_out        = r_out;
  assign o_busy       = (r_state != S_IDLE);
  assign o_hit_frames = r_hit_frames;
  assign o_cmd_frames = r_cmd_frames;

endmodule
`default_nettype wire

// File: tb/tb_cable_tx_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cable_tx_sched : directed table, corner sequences and random traffic vs a queue model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cable_tx_sched;

  localparam int HIT_NIB     = 2;
  localparam int CMD_NIB     = 3;
  localparam int GAP         = 1;
  localparam int MAX_HIT_RUN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [3:0]  out;
  logic        busy;
  logic [15:0] hit_frames;
  logic [15:0] cmd_frames;

  cable_tx_sched_if #(.HIT_NIB(HIT_NIB), .CMD_NIB(CMD_NIB)) tx ();

  cable_tx_sched #(
    .HIT_NIB     (HIT_NIB),
    .CMD_NIB     (CMD_NIB),
    .GAP         (GAP),
    .MAX_HIT_RUN (MAX_HIT_RUN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_en         (en),
    .i_cnt_clr    (cnt_clr),
    .tx           (tx),
    .o_out        (out),
    .o_busy       (busy),
    .o_hit_frames (hit_frames),
    .o_cmd_frames (cmd_frames)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: pending nibbles of the frame in flight; -1 stands for an idle slot.
  int          m_q[$];
  int          m_ph = 0;
  int          m_run = 0;
  logic [15:0] m_hcnt = 16'd0;
  logic [15:0] m_ccnt = 16'd0;
  logic [3:0]  m_out = 4'd0;
  logic        m_hr, m_cr;
  logic        s_hr, s_cr;

  typedef struct {
    logic                 en;
    logic                 hv;
    logic [4*HIT_NIB-1:0] hd;
    logic                 cv;
    logic [4*CMD_NIB-1:0] cd;
    logic                 hr;
    logic                 cr;
    logic [3:0]           out;
    logic                 busy;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [3:0] idle_nib(input int p);
    case (p)
      0:       return 4'b0111;
      1:       return 4'b1011;
      2:       return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_ready();
    logic can;
    can  = !rst && en && (m_q.size() == 0);
    m_hr = can && tx.hit_valid && !(tx.cmd_valid && m_run == MAX_HIT_RUN);
    m_cr = can && tx.cmd_valid && !m_hr;
  endtask

  task automatic model_emit_idle();
    m_out = idle_nib(m_ph);
    m_ph  = (m_ph + 1) % 4;
  endtask

  task automatic model_edge();
    int v;
    if (rst) begin
      m_q.delete();
      m_ph = 0; m_run = 0; m_hcnt = 16'd0; m_ccnt = 16'd0; m_out = 4'd0;
      return;
    end
    if (m_hr) begin
      m_out = 4'b0001;
      for (int i = HIT_NIB - 1; i >= 0; i--) m_q.push_back(int'(tx.hit_data[4*i +: 4]));
      for (int g = 0; g < GAP; g++) m_q.push_back(-1);
      m_run = tx.cmd_valid ? m_run + 1 : 0;
      if (m_hcnt != 16'hFFFF) m_hcnt = m_hcnt + 16'd1;
    end else if (m_cr) begin
      m_out = 4'b0010;
      for (int i = CMD_NIB - 1; i >= 0; i--) m_q.push_back(int'(tx.cmd_data[4*i +: 4]));
      for (int g = 0; g < GAP; g++) m_q.push_back(-1);
      m_run = 0;
      if (m_ccnt != 16'hFFFF) m_ccnt = m_ccnt + 16'd1;
    end else if (m_q.size() > 0) begin
      v = m_q.pop_front();
      if (v < 0) model_emit_idle();
      else       m_out = 4'(v);
    end else begin
      model_emit_idle();
    end
    if (cnt_clr) begin
      m_hcnt = 16'd0;
      m_ccnt = 16'd0;
    end
  endtask

  // One clock: inputs were driven at the preceding negedge.
  task automatic tick();
    #1;
    model_ready();
    s_hr = tx.hit_ready;
    s_cr = tx.cmd_ready;
    chk("hit_ready", 16'(tx.hit_ready), 16'(m_hr));
    chk("cmd_ready", 16'(tx.cmd_ready), 16'(m_cr));
    chk("ready_excl", 16'(tx.hit_ready & tx.cmd_ready), 16'd0);
    model_edge();
    @(posedge clk);
    #1;
    chk("out", 16'(out), 16'(m_out));
    chk("busy", 16'(busy), 16'(m_q.size() != 0));
    chk("hit_frames", hit_frames, m_hcnt);
    chk("cmd_frames", cmd_frames, m_ccnt);
    @(negedge clk);
  endtask

  task automatic set_in(input logic e, input logic hv, input logic [4*HIT_NIB-1:0] hd,
                        input logic cv, input logic [4*CMD_NIB-1:0] cd);
    en = e; tx.hit_valid = hv; tx.hit_data = hd; tx.cmd_valid = cv; tx.cmd_data = cd;
  endtask

  task automatic wait_idle(input string name);
    int k;
    set_in(1'b1, 1'b0, '0, 1'b0, '0);
    k = 0;
    while (busy && k < 20) begin
      tick();
      k++;
    end
    chk({name, "_idle_timeout"}, 16'(busy), 16'd0);
  endtask

  task automatic add(input logic e, input logic hv, input logic [7:0] hd, input logic cv,
                     input logic [11:0] cd, input logic hr, input logic cr,
                     input logic [3:0] o, input logic b);
    vec_t r;
    r.en = e; r.hv = hv; r.hd = hd; r.cv = cv; r.cd = cd;
    r.hr = hr; r.cr = cr; r.out = o; r.busy = b;
    tbl.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gidx;
    tx.hit_valid = 1'b0; tx.hit_data = '0; tx.cmd_valid = 1'b0; tx.cmd_data = '0;

    // Reset for three cycles
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_out", 16'(out), 16'd0);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_hcnt", hit_frames, 16'd0);
    rst = 1'b0;

    // Directed table: idle rotation, hit frame, hit-vs-cmd collision
    add(1, 0, 8'h00, 0, 12'h000, 0, 0, 4'b0111, 0);
    add(1, 0, 8'h00, 0, 12'h000, 0, 0, 4'b1011, 0);
    add(1, 0, 8'h00, 0, 12'h000, 0, 0, 4'b1101, 0);
    add(1, 0, 8'h00, 0, 12'h000, 0, 0, 4'b1110, 0);
    add(1, 0, 8'h00, 0, 12'h000, 0, 0, 4'b0111, 0);
    add(1, 1, 8'hA5, 0, 12'h000, 1, 0, 4'b0001, 1);
    add(1, 0, 8'h00, 0, 12'h000, 0, 0, 4'b1010, 1);
    add(1, 0, 8'h00, 0, 12'h000, 0, 0, 4'b0101, 1);
    add(1, 0, 8'h00, 0, 12'h000, 0, 0, 4'b1011, 0);
    add(1, 1, 8'h5A, 1, 12'h3C9, 1, 0, 4'b0001, 1);
    add(1, 0, 8'h00, 1, 12'h3C9, 0, 0, 4'b0101, 1);
    add(1, 0, 8'h00, 1, 12'h3C9, 0, 0, 4'b1010, 1);
    add(1, 0, 8'h00, 1, 12'h3C9, 0, 0, 4'b1101, 0);
    add(1, 0, 8'h00, 1, 12'h3C9, 0, 1, 4'b0010, 1);
    add(1, 0, 8'h00, 0, 12'h000, 0, 0, 4'b0011, 1);
    add(1, 0, 8'h00, 0, 12'h000, 0, 0, 4'b1100, 1);
    add(1, 0, 8'h00, 0, 12'h000, 0, 0, 4'b1001, 1);
    add(1, 0, 8'h00, 0, 12'h000, 0, 0, 4'b1110, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].en, tbl[i].hv, tbl[i].hd, tbl[i].cv, tbl[i].cd);
      tick();
      chk("tbl_hit_ready", 16'(s_hr), 16'(tbl[i].hr));
      chk("tbl_cmd_ready", 16'(s_cr), 16'(tbl[i].cr));
      chk("tbl_out", 16'(out), 16'(tbl[i].out));
      chk("tbl_busy", 16'(busy), 16'(tbl[i].busy));
    end
    chk("tbl_hit_cnt", hit_frames, 16'd2);
    chk("tbl_cmd_cnt", cmd_frames, 16'd1);

    // Both requesters held: four hit grants then one cmd grant, repeating
    gidx = 0;
    set_in(1'b1, 1'b1, 8'hC3, 1'b1, 12'h6E1);
    repeat (60) begin
      tick();
      if (s_hr || s_cr) begin
        chk("arb_pattern_cmd", 16'(s_cr), 16'((gidx % 5) == 4));
        gidx++;
      end
    end
    chk("arb_grants_seen", 16'(gidx >= 10), 16'd1);

    // en drops one cycle after a grant: frame completes, then idle only
    wait_idle("en_drop");
    set_in(1'b1, 1'b1, 8'h96, 1'b0, '0);
    tick();
    chk("en_drop_grant", 16'(s_hr), 16'd1);
    set_in(1'b0, 1'b1, 8'h96, 1'b1, 12'h123);
    repeat (12) begin
      tick();
      chk("en_low_no_grant", 16'(s_hr | s_cr), 16'd0);
    end
    chk("en_low_idle", 16'(busy), 16'd0);

    // rst in the middle of a payload
    set_in(1'b1, 1'b1, 8'h3F, 1'b0, '0);
    tick();
    set_in(1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_out", 16'(out), 16'd0);
    chk("rst_mid_busy", 16'(busy), 16'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_out", 16'(out), 16'h7);

    // Saturation and clear-vs-grant
    wait_idle("sat");
    force dut.r_hit_frames = 16'hFFFF;
    #1;
    release dut.r_hit_frames;
    m_hcnt = 16'hFFFF;
    set_in(1'b1, 1'b1, 8'h11, 1'b0, '0);
    tick();
    chk("sat_hold", hit_frames, 16'hFFFF);
    wait_idle("clr");
    set_in(1'b1, 1'b1, 8'h22, 1'b0, '0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_wins", hit_frames, 16'd0);

    // Random traffic against the model
    repeat (500) begin
      set_in(($urandom % 8) != 0, $urandom % 2, 8'($urandom), ($urandom % 3) == 0, 12'($urandom));
      cnt_clr = (($urandom % 50) == 0);
      rst     = (($urandom % 150) == 0);
      tick();
    end
    rst = 1'b0;
    cnt_clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
